// File: rtl/network_interface.sv
// Network interface between a local client and a router port: a packetising
// transmit FSM and a first-word-fall-through receive FIFO with sticky overflow.
module network_interface #(
  parameter int NODE_ID  = 7,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid_i,
  input  logic [3:0]  tx_dest_i,
  input  logic [3:0]  tx_len_i,
  output logic        tx_ready_o,
  input  logic        tx_payload_valid_i,
  input  logic [14:0] tx_payload_i,
  output logic        tx_payload_ready_o,
  input  logic        local_full_i,
  output logic [16:0] local_data_o,
  input  logic [16:0] local_data_i,
  output logic        rx_valid_o,
  output logic [15:0] rx_flit_o,
  input  logic        rx_ready_i,
  output logic        rx_overflow_o
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [3:0]    SRC_ID   = 4'(NODE_ID);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } tx_state_t;

  tx_state_t   state_r;
  logic [3:0]  dest_r;
  logic [3:0]  len_r;
  logic [3:0]  remain_r;
  logic [16:0] local_data_s;
  logic        tx_payload_ready_s;
  logic        head_go_s;
  logic        body_go_s;

  // Flit issue: the router sees the flit in the same cycle it has credit.
  always_comb begin
    local_data_s       = 17'd0;
    tx_payload_ready_s = 1'b0;
    head_go_s          = 1'b0;
    body_go_s          = 1'b0;
    case (state_r)
      HEAD: begin
        if (!local_full_i) begin
          local_data_s = {1'b1, 1'b1, dest_r, SRC_ID, len_r, 3'b000};
          head_go_s    = 1'b1;
        end else begin
          local_data_s = 17'd0;
        end
      end
      BODY: begin
        if (tx_payload_valid_i && !local_full_i) begin
          local_data_s       = {1'b1, 1'b0, tx_payload_i};
          tx_payload_ready_s = 1'b1;
          body_go_s          = 1'b1;
        end else begin
          local_data_s       = 17'd0;
          tx_payload_ready_s = 1'b0;
        end
      end
      default: begin
        local_data_s       = 17'd0;
        tx_payload_ready_s = 1'b0;
      end
    endcase
  end

  assign local_data_o       = local_data_s;
  assign tx_payload_ready_o = tx_payload_ready_s;
  assign tx_ready_o         = (state_r == IDLE);

  // TX packet sequencing: request latch, header, then len body flits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      dest_r   <= 4'd0;
      len_r    <= 4'd0;
      remain_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tx_valid_i) begin
            dest_r   <= tx_dest_i;
            len_r    <= tx_len_i;
            remain_r <= tx_len_i;
            state_r  <= HEAD;
          end
        end
        HEAD: begin
          if (head_go_s) begin
            state_r <= (len_r == 4'd0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (body_go_s) begin
            remain_r <= remain_r - 4'd1;
            if (remain_r == 4'd1) begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  logic [15:0]   rx_mem_r [RX_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          overflow_r;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;

  assign push_s  = local_data_i[16];
  assign rx_valid_o = (count_r != {(AW+1){1'b0}});
  assign pop_s   = rx_valid_o && rx_ready_i;
  assign full_s  = (count_r == CNT_FULL);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_s = push_s && (!full_s || pop_s);

  // RX pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever occupancy is zero.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      rx_mem_r[wr_ptr_r] <= local_data_i[15:0];
    end
  end

  assign rx_flit_o     = rx_valid_o ? rx_mem_r[rd_ptr_r] : 16'd0;
  assign rx_overflow_o = overflow_r;

endmodule
